// File: rtl/fp_addsub_mod_resp_pkg.sv
// Curve constants shared by the field-arithmetic responders.
// P is the BLS12-381 base-field prime; FP_BITS is its width.
package fp_addsub_mod_resp_pkg;

  localparam int FP_BITS = 381;

  localparam logic [FP_BITS-1:0] FP_P =
    381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

endpackage

// File: rtl/if_axi_stream.sv
// Generic streaming interface shared across the EC engines and their responders.
// val/rdy handshake: a beat transfers on the rising edge where val & rdy are both high.
interface if_axi_stream #(
  parameter int DAT_BITS = 64,
  parameter int CTL_BITS = 8,
  parameter int MOD_BITS = 3
);
  logic                val;
  logic                rdy;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;
  logic                err;
  logic                sop;
  logic                eop;
  logic [MOD_BITS-1:0] mod;

  modport source (output val, dat, ctl, err, sop, eop, mod, input rdy);
  modport sink   (input val, dat, ctl, err, sop, eop, mod, output rdy);
endinterface

// File: rtl/fp_addsub_mod_resp.sv
// Two-stage mod-P add (SUB=0) or subtract (SUB=1) responder with a tag echo.
// Both stages share one advance enable, so a stalled output freezes the whole pipe.
module fp_addsub_mod_resp
  import fp_addsub_mod_resp_pkg::*;
#(
  parameter int             BITS     = FP_BITS,
  parameter logic [BITS-1:0] P       = FP_P,
  parameter bit             SUB      = 1'b0,
  parameter int             CTL_BITS = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  if_axi_stream.sink    i_if,
  if_axi_stream.source  o_if
);

  logic                en;
  logic [BITS-1:0]     a;
  logic [BITS-1:0]     b;

  logic                s1_val;
  logic [CTL_BITS-1:0] s1_ctl;
  logic                s1_err;
  logic [BITS:0]       s1_raw;

  logic [BITS:0]       raw_nxt;
  logic [BITS-1:0]     res_nxt;

  assign en       = ~o_if.val | o_if.rdy;
  assign i_if.rdy = en;

  assign a = i_if.dat[0+:BITS];
  assign b = i_if.dat[BITS+:BITS];

  generate
    if (SUB) begin : g_sub
      // Bit BITS of the raw difference is the borrow; add P back when it is set.
      assign raw_nxt = {1'b0, a} - {1'b0, b};
      assign res_nxt = s1_raw[BITS] ? s1_raw[BITS-1:0] + P : s1_raw[BITS-1:0];
    end else begin : g_add
      logic [BITS:0] red;
      assign raw_nxt = {1'b0, a} + {1'b0, b};
      assign red     = s1_raw - {1'b0, P};
      assign res_nxt = (s1_raw >= {1'b0, P}) ? red[BITS-1:0] : s1_raw[BITS-1:0];
    end
  endgenerate

  // Stage 1: raw sum/difference, tag and operand-range flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_val <= 1'b0;
      s1_ctl <= '0;
      s1_err <= 1'b0;
      s1_raw <= '0;
    end else if (en) begin
      s1_val <= i_if.val;
      s1_ctl <= i_if.ctl;
      s1_err <= (a >= P) | (b >= P);
      s1_raw <= raw_nxt;
    end
  end

  // Stage 2: reduced result into the output registers; upper dat bits stay 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_if.val <= 1'b0;
      o_if.dat <= '0;
      o_if.ctl <= '0;
      o_if.err <= 1'b0;
      o_if.sop <= 1'b1;
      o_if.eop <= 1'b1;
      o_if.mod <= '0;
    end else begin
      o_if.sop <= 1'b1;
      o_if.eop <= 1'b1;
      o_if.mod <= '0;
      if (en) begin
        o_if.val           <= s1_val;
        o_if.ctl           <= s1_ctl;
        o_if.err           <= s1_err;
        o_if.dat           <= '0;
        o_if.dat[BITS-1:0] <= res_nxt;
      end
    end
  end

endmodule

// File: doc/fp_addsub_mod_resp.md
Name: fp_addsub_mod_resp

Overview:
Responder side of the mod-P add/sub request streams issued by the EC point-arithmetic engines. It accepts tagged operand pairs on an `if_axi_stream` sink and computes (a+b) mod P or (a−b) mod P in a 2-stage pipeline. It returns the result, with the request tag echoed, on an `if_axi_stream` source. The top level instantiates one copy with SUB=0 (adder) and one with SUB=1 (subtractor); each serves one client interface pair.

Parameters:
- BITS, 381, operand/result width; field elements are unsigned, fully reduced.
- P, BLS12-381 base-field prime (BITS wide), modulus.
- SUB, 0, 0 = add, 1 = subtract (a − b).
- CTL_BITS, 16, width of the ctl tag carried through unchanged.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high; clock i_clk.
- i_if  sink (if_axi_stream)  dat ≥ 2*BITS, ctl CTL_BITS  request. a = dat[0+:BITS], b = dat[BITS+:BITS], ctl = tag.
- o_if  source (if_axi_stream)  dat ≥ BITS, ctl CTL_BITS  response. dat[0+:BITS] = result; ctl = echoed tag; err = operand-range flag.

Behaviour:
- Reset: o_if.val=0, o_if.dat=0, o_if.ctl=0, o_if.err=0, o_if.sop=1, o_if.eop=1, o_if.mod=0; stage-1 valid (s1_val)=0.
- Reset mid-operation: all in-flight requests are dropped; no response is issued for them.
- Pipeline advance enable: en = ~o_if.val | o_if.rdy.
  - Combinational: i_if.rdy = en.
  - The same en gates both stages, so the pipeline holds fully when stalled.
- Stage 1, loaded when en:
  - s1_val <= i_if.val; s1_ctl <= i_if.ctl.
  - SUB=0: s1_raw <= {1'b0,a} + {1'b0,b} (BITS+1 bits).
  - SUB=1: s1_raw <= {1'b0,a} − {1'b0,b}; bit BITS is the borrow.
  - s1_err <= (a ≥ P) | (b ≥ P).
- Stage 2 (output registers), loaded when en:
  - o_if.val <= s1_val; o_if.ctl <= s1_ctl; o_if.err <= s1_err.
  - SUB=0: dat <= (s1_raw ≥ P) ? s1_raw − P : s1_raw, truncated to BITS.
  - SUB=1: dat <= borrow ? (s1_raw[BITS−1:0] + P) mod 2^BITS : s1_raw[BITS−1:0].
  - Upper dat bits beyond BITS are driven 0.
- Latency: 2 cycles from the accepting edge to o_if.val with no backpressure.
- Throughput: 1 request per cycle sustained while o_if.rdy=1.
- Backpressure:
  - o_if.val=1 & o_if.rdy=0 → both stages hold, i_if.rdy=0, dat and ctl stable.
  - While held, at most 2 transactions are in flight.
- Simultaneous accept and retire in one cycle is legal.
- Bubbles: i_if.val=0 while en=1 inserts a bubble, and o_if.val drops the next cycle.
- Ordering is strict FIFO; responses are never reordered or duplicated.
- Out-of-range operands:
  - The result is still computed by the formulas above; no extra reduction is applied.
  - o_if.err=1 on that beat only.
- Boundary results: a+b = P → 0; a+b = 2P−2 → P−2; a = b (sub) → 0; 0 − (P−1) → 1.

Decomposition:
- No new package types. P and BITS come from the existing curve package constants (e.g. the BLS12-381 P).
- `if_axi_stream` is reused unchanged.
- No sub-module: add and sub share the same skeleton, selected by generate on SUB.

Test Plan:
- BITS=8, P=251, SUB=0: a=200, b=100, ctl=0x10 → dat=49, ctl=0x10, o_if.val exactly 2 cycles after accept, err=0.
- BITS=8, P=251, SUB=1: a=3, b=5 → 249; a=7, b=7 → 0; a=0, b=250 → 1.
- Back-to-back: 100 random pairs sent with o_if.rdy=1 → one result per cycle, ctl tags in order, every result matches the mod-P reference model.
- Backpressure: o_if.rdy held 0 for 5 cycles with a continuous input stream → i_if.rdy=0 after 2 accepts. Output beat stable while held; no loss or duplication after release.
- Range error: SUB=0, a=252, b=1 → err=1 on that beat only; the next beat (a=1, b=1) → dat=2, err=0.
- Reset mid-flight: 2 requests in the pipe, i_rst pulsed for 1 cycle → o_if.val=0 the cycle after reset and no stale responses afterwards. A new request a=1, b=2 → 3.
